// File: rtl/run_controller_pkg.sv
// Shared types for the CPU run controller: CPU error flags, controller states,
// host command opcodes and halt causes.
// Pure type/constant package, no logic, no latency, no flow control.
package run_controller_pkg;

    // One flag per CPU fault source; any non-zero value is a fault.
    typedef struct packed {
        logic decoder;
        logic alu;
    } CpuError;

    typedef enum logic [2:0] {
        RESETTING = 3'd0,
        IDLE      = 3'd1,
        RUNNING   = 3'd2,
        STEPPING  = 3'd3,
        STOPPED   = 3'd4,
        FAULT     = 3'd5
    } RunState;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        STEP    = 2'd1,
        HALT    = 2'd2,
        RESTART = 2'd3
    } RunCmd;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        EBREAK = 2'd1,
        ERROR  = 2'd2,
        HOST   = 2'd3
    } HaltCause;

endpackage

// File: rtl/run_controller.sv
// Sequences the CPU: reset pulse, clock enable for run / N-step, host halt and restart,
// halt-cause latching and a saturating executed-cycle counter.
// State updates one clk after an accepted command; cpu_enable masks combinationally on stop/error.
// Ports: clk/reset (sync, active-high); cmd_valid/cmd_ready/cmd_op/cmd_steps host command
// handshake (cmd_ready low only while RESETTING); cpu_stop/cpu_error from CPU; cpu_reset/
// cpu_enable to CPU; state/halt_cause/error_latched/cycle_count status.
module run_controller
    import run_controller_pkg::*;
#(
    parameter int RESET_CYCLES = 2,
    parameter int CYCLE_WIDTH  = 32,
    parameter int STEP_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  RunCmd                  cmd_op,
    input  logic [STEP_WIDTH-1:0]  cmd_steps,
    input  logic                   cpu_stop,
    input  CpuError                cpu_error,
    output logic                   cpu_reset,
    output logic                   cpu_enable,
    output RunState                state,
    output HaltCause               halt_cause,
    output CpuError                error_latched,
    output logic [CYCLE_WIDTH-1:0] cycle_count
);

    // Counter holds RESET_CYCLES-1 down to 0, so clog2(RESET_CYCLES) bits suffice.
    localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RCW-1:0] RST_LOAD = RCW'(RESET_CYCLES - 1);

    logic [RCW-1:0]         rst_cnt, rst_cnt_nxt;
    logic [STEP_WIDTH-1:0]  step_cnt, step_cnt_nxt;
    logic [CYCLE_WIDTH-1:0] cycle_cnt_nxt;
    RunState                state_nxt;
    HaltCause               cause_nxt;
    CpuError                err_nxt;
    logic                   cmd_acc;
    logic                   fault;

    assign cmd_ready = (state != RESETTING);
    assign cmd_acc   = cmd_valid && cmd_ready;
    assign fault     = (cpu_error != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= RESETTING;
            rst_cnt       <= RST_LOAD;
            step_cnt      <= '0;
            cycle_count   <= '0;
            halt_cause    <= NONE;
            error_latched <= '0;
        end else begin
            state         <= state_nxt;
            rst_cnt       <= rst_cnt_nxt;
            step_cnt      <= step_cnt_nxt;
            cycle_count   <= cycle_cnt_nxt;
            halt_cause    <= cause_nxt;
            error_latched <= err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        rst_cnt_nxt   = rst_cnt;
        step_cnt_nxt  = step_cnt;
        cycle_cnt_nxt = cycle_count;
        cause_nxt     = halt_cause;
        err_nxt       = error_latched;
        cpu_reset     = 1'b0;
        cpu_enable    = 1'b0;

        unique case (state)
            RESETTING: begin
                // CPU clock runs during reset so the CPU sees reset edges; stop/error ignored.
                cpu_reset  = 1'b1;
                cpu_enable = 1'b1;
                if (rst_cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    rst_cnt_nxt = rst_cnt - RCW'(1);
                end
            end
            IDLE: begin
                if (cmd_acc) begin
                    if (cmd_op == RUN) begin
                        state_nxt = RUNNING;
                    end else if (cmd_op == STEP && cmd_steps != '0) begin
                        state_nxt    = STEPPING;
                        step_cnt_nxt = cmd_steps;
                    end
                end
            end
            RUNNING, STEPPING: begin
                // Kill the clock in the very cycle stop/error shows up so nothing
                // executes past the offending instruction.
                cpu_enable = !cpu_stop && !fault;
                if (fault) begin
                    state_nxt = FAULT;
                    err_nxt   = cpu_error;
                    cause_nxt = ERROR;
                end else if (cpu_stop) begin
                    state_nxt = STOPPED;
                    cause_nxt = EBREAK;
                end else if (cmd_acc && cmd_op == HALT) begin
                    state_nxt = IDLE;
                    cause_nxt = HOST;
                end else if (state == STEPPING) begin
                    if (step_cnt == STEP_WIDTH'(1)) begin
                        state_nxt = IDLE;
                    end else begin
                        step_cnt_nxt = step_cnt - STEP_WIDTH'(1);
                    end
                end
            end
            default: begin
                // STOPPED / FAULT: parked until RESTART.
            end
        endcase

        if (cpu_enable && !cpu_reset && cycle_count != '1) begin
            cycle_cnt_nxt = cycle_count + CYCLE_WIDTH'(1);
        end

        // RESTART outranks everything, including a fault raised in the same cycle.
        if (cmd_acc && cmd_op == RESTART) begin
            state_nxt     = RESETTING;
            rst_cnt_nxt   = RST_LOAD;
            cycle_cnt_nxt = '0;
            cause_nxt     = NONE;
            err_nxt       = '0;
        end
    end

endmodule
